// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enable/flush for load-use stalls, taken-branch
// squashes and data-memory waits, plus saturating statistics and a sticky timeout flag.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {StInit, StRun, StFlush, StMemWait} state_e;

    localparam logic [1:0]       FlushLoad  = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       WaitMax    = 8'(MEM_TIMEOUT);
    localparam bit               MultiFlush = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_timeout_q, mem_timeout_d;
    logic             branch_accept;
    logic             load_use;

    assign load_use = ex_mem_read & ex_regwrite & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        wcnt_d        = wcnt_q;
        mem_timeout_d = mem_timeout_q;
        branch_accept = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;

        unique case (state_q)
            StInit: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_en    = 1'b0;
                exmem_en   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = StRun;
            end
            StRun: begin
                if (mem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    wcnt_d   = 8'd1;
                    state_d  = StMemWait;
                end else if (branch_taken) begin
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    branch_accept = 1'b1;
                    if (MultiFlush) begin
                        fcnt_d  = FlushLoad;
                        state_d = StFlush;
                    end
                end else if (load_use) begin
                    // Hold PC and IF/ID, inject a bubble behind the load.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            StFlush: begin
                if (mem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end else begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    fcnt_d     = fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StMemWait: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                if (!mem_busy) begin
                    wcnt_d  = 8'd0;
                    state_d = StRun;
                end else if (wcnt_q == WaitMax) begin
                    // Leave to RUN so the error surfaces; RUN re-freezes if still busy.
                    mem_timeout_d = 1'b1;
                    wcnt_d        = 8'd0;
                    state_d       = StRun;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StInit;
            fcnt_q        <= 2'd0;
            wcnt_q        <= 8'd0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
            if ((state_q != StInit) && !pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (branch_accept && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes reference-model expectations,
// monitor pops and compares once per cycle on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    localparam logic [5:0] CtlInit   = 6'b001010;
    localparam logic [5:0] CtlRun    = 6'b110101;
    localparam logic [5:0] CtlFlush  = 6'b111111;
    localparam logic [5:0] CtlLdUse  = 6'b000111;
    localparam logic [5:0] CtlFreeze = 6'b000000;

    logic          clk = 1'b1;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rt, ex_mem_read, ex_regwrite, branch_taken, mem_busy;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_timeout;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_regwrite (ex_regwrite),
        .ex_rd       (ex_rd),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .mem_timeout (mem_timeout)
    );

    typedef struct {
        bit            chk;
        logic [5:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          tmo;
    } exp_t;

    exp_t sbq[$];
    int   nchk  = 0;
    int   npass = 0;
    int   cyc   = 0;

    // Reference model: plain counters of pending work rather than a state encoding.
    bit m_init      = 1'b1;
    int m_flush_left = 0;
    bit m_wait      = 1'b0;
    int m_wait_n    = 0;
    int m_stalls    = 0;
    int m_flushes   = 0;
    bit m_tmo       = 1'b0;

    function automatic logic [CW-1:0] sat(input int n);
        int lim;
        lim = (1 << CW) - 1;
        return CW'((n > lim) ? lim : n);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic step(input logic rn, input logic bs, input logic br, input logic mr,
                        input logic rw, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt);
        exp_t e;
        bit   lu;
        rst_n = rn; mem_busy = bs; branch_taken = br; ex_mem_read = mr;
        ex_regwrite = rw; ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        e.chk = rn;
        e.sc  = sat(m_stalls);
        e.fc  = sat(m_flushes);
        e.tmo = m_tmo;
        e.ctl = CtlFreeze;
        lu = mr && rw && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
        if (!rn) begin
            m_init = 1'b1; m_flush_left = 0; m_wait = 1'b0; m_wait_n = 0;
            m_stalls = 0; m_flushes = 0; m_tmo = 1'b0;
        end else if (m_init) begin
            e.ctl  = CtlInit;
            m_init = 1'b0;
        end else if (m_wait) begin
            m_stalls++;
            if (!bs) m_wait = 1'b0;
            else if (m_wait_n == TO) begin m_tmo = 1'b1; m_wait = 1'b0; end
            else m_wait_n++;
        end else if (m_flush_left > 0) begin
            if (bs) m_stalls++;
            else begin e.ctl = CtlFlush; m_flush_left--; end
        end else if (bs) begin
            m_stalls++;
            m_wait   = 1'b1;
            m_wait_n = 1;
        end else if (br) begin
            e.ctl = CtlFlush;
            m_flushes++;
            m_flush_left = FC - 1;
        end else if (lu) begin
            e.ctl = CtlLdUse;
            m_stalls++;
        end else begin
            e.ctl = CtlRun;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    check("stage_ctl", {2'b00, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                        exmem_en}, {2'b00, e.ctl});
                    check("stall_cnt", 8'(stall_cnt), 8'(e.sc));
                    check("flush_cnt", 8'(flush_cnt), 8'(e.fc));
                    check("mem_timeout", 8'(mem_timeout), 8'(e.tmo));
                end
            end
            cyc++;
        end
    end

    // Driver
    initial begin
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(3);
        // Load-use: rs match, rd==0, rt match without uses_rt, rt match with uses_rt
        step(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        idle(1);
        step(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5, 0);
        step(1, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5, 1);
        idle(1);
        // Branch, with a load-use in the squash cycle
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 1, 1, 5'd7, 5'd7, 5'd0, 0);
        idle(1);
        // mem_busy + branch together, branch held through the wait
        step(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);
        // Timeout: busy for 10 cycles, flag sticky until reset
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);
        // Reset mid-wait
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);
        // Stall counter saturation
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)));
        end
        idle(2);
        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        nchk++;
        if (sbq.size() == 0) npass++;
        else $display("FAIL drain: got %0d pending expected 0", sbq.size());
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
